nes_pad_reader: RTL and testbench



---
 rtl/nes_pad_reader_pkg.sv | 23 ++
 rtl/nes_pad_reader_sync_2ff.sv | 21 ++
 rtl/nes_pad_reader.sv | 138 +++++++++++++
 tb/tb_nes_pad_reader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES controller reader: button bit positions,
// reader FSM states and serial frame length.
package ControllerPkg;
  localparam int PAD_BITS  = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    WAIT0  = 3'd2,
    CLK_LO = 3'd3,
    CLK_HI = 3'd4,
    DONE   = 3'd5
  } pad_state_t;
endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer for the pad serial line; resets to 1 (idle/pulled-up).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/nes_pad_reader.sv
// Console-side NES pad reader: latches the pad's 4021, clocks out 8 bits,
// and presents them as an active-high button byte with a valid pulse.
module nes_pad_reader
  import ControllerPkg::*;
#(
  parameter int HALF_CYC      = 150,
  parameter int POLL_INTERVAL = 416667
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_req,
  input  logic       auto_en,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);
  localparam int PW = $clog2(2*HALF_CYC);
  localparam int IW = $clog2(POLL_INTERVAL);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2*HALF_CYC-1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC-1);
  localparam logic [IW-1:0] IVL_LAST   = IW'(POLL_INTERVAL-1);
  localparam logic [2:0]    LAST_BIT   = 3'(PAD_BITS-1);

  pad_state_t    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    btn_q, btn_d;
  logic          latch_q, latch_d;
  logic          pclk_q, pclk_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          data_s, auto_tick, sample;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_data),
    .q     (data_s)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bit_d     = bit_q;
    sr_d      = sr_q;
    sample    = 1'b0;
    auto_tick = auto_en && (ivl_q == IVL_LAST);

    if (!auto_en || auto_tick) ivl_d = '0;
    else                       ivl_d = ivl_q + 1'b1;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (poll_req || auto_tick) begin
          state_d = LATCH;
          bit_d   = '0;
        end
      end
      LATCH: if (phase_q == LATCH_LAST) begin
        state_d = WAIT0;
        phase_d = '0;
      end
      WAIT0: if (phase_q == HALF_LAST) begin
        sample  = 1'b1;
        state_d = CLK_LO;
        phase_d = '0;
      end
      CLK_LO: if (phase_q == HALF_LAST) begin
        state_d = CLK_HI;
        phase_d = '0;
      end
      CLK_HI: if (phase_q == HALF_LAST) begin
        sample  = 1'b1;
        phase_d = '0;
        state_d = (bit_q == LAST_BIT) ? DONE : CLK_LO;
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // pad line is active-low; store pressed as 1
    if (sample) begin
      sr_d[bit_q] = ~data_s;
      bit_d       = bit_q + 1'b1;
    end

    // outputs follow the next state so they line up with it cycle-for-cycle
    latch_d = (state_d == LATCH);
    pclk_d  = (state_d != CLK_LO);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
    btn_d   = valid_d ? sr_d : btn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      ivl_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      btn_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ivl_q   <= ivl_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      btn_q   <= btn_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons   = btn_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader with a behavioural 4021 pad model and a
// scoreboard of expected button bytes.
module tb_nes_pad_reader;
  localparam int H   = 4;
  localparam int PI  = 200;
  localparam int LAT = 17*H + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_req = 1'b0;
  logic       auto_en = 1'b0;
  logic       pad_latch, pad_clk, pad_data, valid, busy;
  logic [7:0] buttons;

  nes_pad_reader #(.HALF_CYC(H), .POLL_INTERVAL(PI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .poll_req  (poll_req),
    .auto_en   (auto_en),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4021 model: parallel load while latch high, shift toward Q8 on pad_clk rise
  logic [7:0] pressed = 8'h00;
  logic       present = 1'b1;
  logic [7:0] pad_sr  = 8'hFF;
  always @(posedge pad_clk or posedge pad_latch)
    if (pad_latch) pad_sr <= ~pressed;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  assign pad_data = present ? pad_sr[0] : 1'b1;

  typedef struct {
    logic [7:0] pressed;
    logic       present;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_btn = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name);
    if (exp_q.size() == 0) check({name, "_sb_empty"}, 1, 0);
    else                   check(name, buttons, exp_q.pop_front());
  endtask

  task automatic do_poll(input vec_t v);
    int   c, lat_cyc, falls;
    logic pc_prev;
    bit   seen;
    pressed = v.pressed;
    present = v.present;
    @(negedge clk);
    c = cyc;
    exp_q.push_back(v.exp);
    poll_req = 1'b1;
    lat_cyc = 0; falls = 0; pc_prev = 1'b1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      poll_req = 1'b0;
      if (pad_latch) lat_cyc++;
      if (pc_prev && !pad_clk) falls++;
      pc_prev = pad_clk;
      if (cyc == c + 40) check("buttons_hold", buttons, prev_btn);
      if (valid) begin
        seen = 1'b1;
        check("latency", cyc - c, LAT);
        sb_compare("buttons");
        check("latch_cycles", lat_cyc, 2*H);
        check("clk_pulses", falls, 7);
        check("busy_in_done", busy, 1);
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
    prev_btn = v.exp;
    @(negedge clk);
    check("busy_after", busy, 0);
    check("valid_one_cycle", valid, 0);
  endtask

  initial begin
    int c, nv, rises, stim_a, stim_b, vcount;
    int vcyc[4];
    logic lp;

    vecs[0] = '{8'h09, 1'b1, 8'h09};  // A + Start
    vecs[1] = '{8'h5A, 1'b0, 8'h00};  // no pad: line pulled high
    vecs[2] = '{8'hFF, 1'b1, 8'hFF};  // everything pressed
    vecs[3] = '{8'h10, 1'b1, 8'h10};  // Up
    vecs[4] = '{8'h40, 1'b1, 8'h40};  // Left; Up must hold until valid
    vecs[5] = '{8'hA5, 1'b1, 8'hA5};

    repeat (2) @(negedge clk);
    check("rst_latch", pad_latch, 0);
    check("rst_pclk", pad_clk, 1);
    check("rst_buttons", buttons, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_poll(vecs[i]);

    // reset in the middle of a poll
    do_poll(vecs[0]);
    @(negedge clk);
    c = cyc;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    while (cyc < c + 30) @(negedge clk);
    check("mid_pclk_low", pad_clk, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_latch", pad_latch, 0);
    check("mid_rst_pclk", pad_clk, 1);
    check("mid_rst_buttons", buttons, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    prev_btn = 8'h00;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("no_valid_after_rst", vcount, 0);
    do_poll(vecs[5]);

    // periodic polling, with a mid-poll request and a coincident request
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    pressed = 8'h22;
    present = 1'b1;
    auto_en = 1'b1;
    rst_n   = 1'b1;
    nv = 0; rises = 0; stim_a = -1; stim_b = -1; lp = 1'b0;
    for (int i = 0; i < 1200 && nv < 4; i++) begin
      @(negedge clk);
      poll_req = (cyc == stim_a) || (cyc == stim_b);
      if (pad_latch && !lp) begin
        rises++;
        exp_q.push_back(8'h22);
      end
      lp = pad_latch;
      if (valid) begin
        vcyc[nv] = cyc;
        sb_compare("auto_buttons");
        nv++;
        if (nv == 1) stim_a = cyc + (PI - LAT) + 30;
        if (nv == 2) stim_b = cyc + (PI - LAT);
      end
    end
    poll_req = 1'b0;
    auto_en  = 1'b0;
    check("auto_valid_count", nv, 4);
    if (nv == 4) begin
      check("auto_period1", vcyc[1] - vcyc[0], PI);
      check("auto_period2", vcyc[2] - vcyc[1], PI);
      check("auto_period3", vcyc[3] - vcyc[2], PI);
    end
    check("auto_latch_pulses", rises, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
